// File: rtl/load_miss_queue.sv
// Load miss queue: parks cacheable loads that missed in the data cache,
// tracks up to NMSHR outstanding line refills, merges loads that hit a
// pending line, issues one refill request at a time and replays woken
// loads back to the load pipeline at up to one per cycle.
module load_miss_queue #(
    parameter int NMSHR = 2,
    parameter int DEPTH = 8,
    parameter int OFFB  = 7,
    parameter int IDW   = (NMSHR > 1) ? $clog2(NMSHR) : 1
) (
    input  logic            core_clock_i,
    input  logic            core_reset_n_i,
    input  logic            core_flush_i,
    input  logic            enq_vld_i,
    input  logic [5:0]      enq_rob_i,
    input  logic [2:0]      enq_op_i,
    input  logic [31:0]     enq_addr_i,
    input  logic [5:0]      enq_dest_i,
    output logic            enq_rdy_o,
    output logic            dc_req_o,
    output logic [31:0]     dc_addr_o,
    output logic [IDW-1:0]  dc_id_o,
    input  logic            dc_ack_i,
    input  logic            dc_cmp_i,
    input  logic [IDW-1:0]  dc_cmp_id_i,
    output logic            rp_vld_o,
    output logic [5:0]      rp_rob_o,
    output logic [2:0]      rp_op_o,
    output logic [31:0]     rp_addr_o,
    output logic [5:0]      rp_dest_o,
    input  logic            rp_rdy_i,
    output logic            full_o,
    output logic            empty_o
);

    localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = 32 - OFFB;

    // Parked-load slots
    logic [DEPTH-1:0] slot_vld_q, slot_vld_d;
    logic [DEPTH-1:0] slot_wkn_q, slot_wkn_d;
    logic [IDW-1:0]   slot_id_q   [DEPTH];
    logic [IDW-1:0]   slot_id_d   [DEPTH];
    logic [5:0]       slot_rob_q  [DEPTH];
    logic [5:0]       slot_rob_d  [DEPTH];
    logic [2:0]       slot_op_q   [DEPTH];
    logic [2:0]       slot_op_d   [DEPTH];
    logic [31:0]      slot_addr_q [DEPTH];
    logic [31:0]      slot_addr_d [DEPTH];
    logic [5:0]       slot_dest_q [DEPTH];
    logic [5:0]       slot_dest_d [DEPTH];

    // Miss status holding registers
    logic [NMSHR-1:0] mshr_vld_q, mshr_vld_d;
    logic [NMSHR-1:0] mshr_iss_q, mshr_iss_d;
    logic [LW-1:0]    mshr_line_q [NMSHR];
    logic [LW-1:0]    mshr_line_d [NMSHR];

    // Refill request and replay output registers
    logic             dc_req_q, dc_req_d;
    logic [31:0]      dc_addr_q, dc_addr_d;
    logic [IDW-1:0]   dc_id_q, dc_id_d;
    logic             rp_vld_q, rp_vld_d;
    logic [SW-1:0]    rp_slot_q, rp_slot_d;
    logic [5:0]       rp_rob_q, rp_rob_d;
    logic [2:0]       rp_op_q, rp_op_d;
    logic [31:0]      rp_addr_q, rp_addr_d;
    logic [5:0]       rp_dest_q, rp_dest_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;

    // Combinational helpers
    logic [LW-1:0]    enq_line_s;
    logic             hit_s;
    logic [IDW-1:0]   hit_id_s;
    logic             slot_free_any_s;
    logic [SW-1:0]    free_slot_s;
    logic             mshr_free_any_s;
    logic [IDW-1:0]   free_mshr_s;
    logic             enq_fire_s;
    logic [IDW-1:0]   enq_id_s;
    logic             enq_wkn_s;
    logic             rp_hs_s;
    logic             ack_hs_s;
    logic             rf_sel_any_s;
    logic [IDW-1:0]   rf_sel_s;
    logic             rp_sel_any_s;
    logic [SW-1:0]    rp_sel_s;

    assign enq_line_s = enq_addr_i[31:OFFB];
    assign rp_hs_s    = rp_vld_q & rp_rdy_i;
    assign ack_hs_s   = dc_req_q & dc_ack_i;

    // Line match against valid MSHRs and lowest free MSHR / slot search
    always_comb begin
        hit_s           = 1'b0;
        hit_id_s        = {IDW{1'b0}};
        mshr_free_any_s = 1'b0;
        free_mshr_s     = {IDW{1'b0}};
        slot_free_any_s = 1'b0;
        free_slot_s     = {SW{1'b0}};
        for (int m = NMSHR - 1; m >= 0; m--) begin
            hit_s           = hit_s | (mshr_vld_q[m] & (mshr_line_q[m] == enq_line_s));
            hit_id_s        = (mshr_vld_q[m] && (mshr_line_q[m] == enq_line_s)) ? IDW'(m) : hit_id_s;
            mshr_free_any_s = mshr_free_any_s | ~mshr_vld_q[m];
            free_mshr_s     = (!mshr_vld_q[m]) ? IDW'(m) : free_mshr_s;
        end
        for (int s = DEPTH - 1; s >= 0; s--) begin
            slot_free_any_s = slot_free_any_s | ~slot_vld_q[s];
            free_slot_s     = (!slot_vld_q[s]) ? SW'(s) : free_slot_s;
        end
    end

    assign enq_rdy_o  = ~core_flush_i & slot_free_any_s & (hit_s | mshr_free_any_s);
    assign enq_fire_s = enq_vld_i & enq_rdy_o;
    assign enq_id_s   = hit_s ? hit_id_s : free_mshr_s;
    // A load merging into a line that completes this very cycle must not miss its wakeup
    assign enq_wkn_s  = hit_s & dc_cmp_i & (dc_cmp_id_i == hit_id_s);

    // Slot next state: flush, replay free, enqueue write, completion wakeup
    always_comb begin
        slot_vld_d  = slot_vld_q;
        slot_wkn_d  = slot_wkn_q;
        slot_id_d   = slot_id_q;
        slot_rob_d  = slot_rob_q;
        slot_op_d   = slot_op_q;
        slot_addr_d = slot_addr_q;
        slot_dest_d = slot_dest_q;
        for (int s = 0; s < DEPTH; s++) begin
            if (core_flush_i) begin
                slot_vld_d[s] = 1'b0;
                slot_wkn_d[s] = 1'b0;
            end else if (rp_hs_s && (rp_slot_q == SW'(s))) begin
                slot_vld_d[s] = 1'b0;
                slot_wkn_d[s] = 1'b0;
            end else if (enq_fire_s && (free_slot_s == SW'(s))) begin
                slot_vld_d[s]  = 1'b1;
                slot_wkn_d[s]  = enq_wkn_s;
                slot_id_d[s]   = enq_id_s;
                slot_rob_d[s]  = enq_rob_i;
                slot_op_d[s]   = enq_op_i;
                slot_addr_d[s] = enq_addr_i;
                slot_dest_d[s] = enq_dest_i;
            end else begin
                slot_vld_d[s] = slot_vld_q[s];
                slot_wkn_d[s] = slot_wkn_q[s] |
                                (dc_cmp_i & slot_vld_q[s] & (slot_id_q[s] == dc_cmp_id_i));
            end
        end
    end

    // MSHR next state: completion frees, allocation, ack marks issued, flush drops unissued
    always_comb begin
        mshr_vld_d  = mshr_vld_q;
        mshr_iss_d  = mshr_iss_q;
        mshr_line_d = mshr_line_q;
        for (int m = 0; m < NMSHR; m++) begin
            if (dc_cmp_i && (dc_cmp_id_i == IDW'(m))) begin
                mshr_vld_d[m] = 1'b0;
                mshr_iss_d[m] = 1'b0;
            end else if (enq_fire_s && !hit_s && (free_mshr_s == IDW'(m))) begin
                mshr_vld_d[m]  = 1'b1;
                mshr_iss_d[m]  = 1'b0;
                mshr_line_d[m] = enq_line_s;
            end else if (ack_hs_s && (dc_id_q == IDW'(m))) begin
                mshr_vld_d[m] = mshr_vld_q[m];
                mshr_iss_d[m] = 1'b1;
            end else begin
                mshr_vld_d[m] = mshr_vld_q[m];
                mshr_iss_d[m] = mshr_iss_q[m];
            end
            // Issued refills keep their MSHR across a flush so the line stays matchable
            mshr_vld_d[m] = core_flush_i ? (mshr_vld_d[m] & mshr_iss_d[m]) : mshr_vld_d[m];
        end
    end

    // Refill request: hold while stalled, otherwise pick lowest pending MSHR of next state
    always_comb begin
        rf_sel_any_s = 1'b0;
        rf_sel_s     = {IDW{1'b0}};
        for (int m = NMSHR - 1; m >= 0; m--) begin
            rf_sel_any_s = rf_sel_any_s | (mshr_vld_d[m] & ~mshr_iss_d[m]);
            rf_sel_s     = (mshr_vld_d[m] && !mshr_iss_d[m]) ? IDW'(m) : rf_sel_s;
        end
        if (dc_req_q && !dc_ack_i && !core_flush_i) begin
            dc_req_d  = dc_req_q;
            dc_addr_d = dc_addr_q;
            dc_id_d   = dc_id_q;
        end else begin
            dc_req_d  = rf_sel_any_s;
            dc_addr_d = {mshr_line_d[rf_sel_s], {OFFB{1'b0}}};
            dc_id_d   = rf_sel_s;
        end
    end

    // Replay output: hold under backpressure, else present lowest woken slot not leaving now
    always_comb begin
        rp_sel_any_s = 1'b0;
        rp_sel_s     = {SW{1'b0}};
        for (int s = DEPTH - 1; s >= 0; s--) begin
            rp_sel_any_s = rp_sel_any_s |
                           (slot_vld_q[s] & slot_wkn_q[s] & ~(rp_hs_s & (rp_slot_q == SW'(s))));
            rp_sel_s     = (slot_vld_q[s] && slot_wkn_q[s] && !(rp_hs_s && (rp_slot_q == SW'(s))))
                           ? SW'(s) : rp_sel_s;
        end
        rp_slot_d = rp_slot_q;
        rp_rob_d  = rp_rob_q;
        rp_op_d   = rp_op_q;
        rp_addr_d = rp_addr_q;
        rp_dest_d = rp_dest_q;
        if (core_flush_i) begin
            rp_vld_d = 1'b0;
        end else if (rp_vld_q && !rp_rdy_i) begin
            rp_vld_d = rp_vld_q;
        end else begin
            rp_vld_d  = rp_sel_any_s;
            rp_slot_d = rp_sel_s;
            rp_rob_d  = slot_rob_q[rp_sel_s];
            rp_op_d   = slot_op_q[rp_sel_s];
            rp_addr_d = slot_addr_q[rp_sel_s];
            rp_dest_d = slot_dest_q[rp_sel_s];
        end
    end

    // Occupancy flags from next-state valid bits
    always_comb begin
        full_d  = &slot_vld_d;
        empty_d = ~(|slot_vld_d) & ~(|mshr_vld_d);
    end

    // State registers with synchronous active-low reset of all control state
    always_ff @(posedge core_clock_i) begin
        if (!core_reset_n_i) begin
            slot_vld_q <= {DEPTH{1'b0}};
            slot_wkn_q <= {DEPTH{1'b0}};
            mshr_vld_q <= {NMSHR{1'b0}};
            mshr_iss_q <= {NMSHR{1'b0}};
            dc_req_q   <= 1'b0;
            rp_vld_q   <= 1'b0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
        end else begin
            slot_vld_q <= slot_vld_d;
            slot_wkn_q <= slot_wkn_d;
            mshr_vld_q <= mshr_vld_d;
            mshr_iss_q <= mshr_iss_d;
            dc_req_q   <= dc_req_d;
            rp_vld_q   <= rp_vld_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
        end
        slot_id_q   <= slot_id_d;
        slot_rob_q  <= slot_rob_d;
        slot_op_q   <= slot_op_d;
        slot_addr_q <= slot_addr_d;
        slot_dest_q <= slot_dest_d;
        mshr_line_q <= mshr_line_d;
        dc_addr_q   <= dc_addr_d;
        dc_id_q     <= dc_id_d;
        rp_slot_q   <= rp_slot_d;
        rp_rob_q    <= rp_rob_d;
        rp_op_q     <= rp_op_d;
        rp_addr_q   <= rp_addr_d;
        rp_dest_q   <= rp_dest_d;
    end

    assign dc_req_o  = dc_req_q;
    assign dc_addr_o = dc_addr_q;
    assign dc_id_o   = dc_id_q;
    assign rp_vld_o  = rp_vld_q;
    assign rp_rob_o  = rp_rob_q;
    assign rp_op_o   = rp_op_q;
    assign rp_addr_o = rp_addr_q;
    assign rp_dest_o = rp_dest_q;
    assign full_o    = full_q;
    assign empty_o   = empty_q;

endmodule

// File: tb/tb_load_miss_queue.sv
// Scoreboard bench for load_miss_queue (NMSHR=2, DEPTH=8, OFFB=7).
module tb_load_miss_queue;

    localparam int IDW = 1;

    logic           clk = 1'b0;
    logic           core_reset_n_i, core_flush_i;
    logic           enq_vld_i, enq_rdy_o;
    logic [5:0]     enq_rob_i, enq_dest_i;
    logic [2:0]     enq_op_i;
    logic [31:0]    enq_addr_i;
    logic           dc_req_o, dc_ack_i, dc_cmp_i;
    logic [31:0]    dc_addr_o;
    logic [IDW-1:0] dc_id_o, dc_cmp_id_i;
    logic           rp_vld_o, rp_rdy_i, full_o, empty_o;
    logic [5:0]     rp_rob_o, rp_dest_o;
    logic [2:0]     rp_op_o;
    logic [31:0]    rp_addr_o;

    typedef struct {
        logic [5:0]  rob;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [5:0]  dest;
    } rp_t;
    typedef struct {
        logic [31:0]    addr;
        logic [IDW-1:0] id;
    } rf_t;

    rp_t rp_q[$];
    rf_t rf_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    logic [1:0] tb_iss = 2'b00;

    always #5 clk = ~clk;

    load_miss_queue dut (
        .core_clock_i   (clk),
        .core_reset_n_i (core_reset_n_i),
        .core_flush_i   (core_flush_i),
        .enq_vld_i      (enq_vld_i),
        .enq_rob_i      (enq_rob_i),
        .enq_op_i       (enq_op_i),
        .enq_addr_i     (enq_addr_i),
        .enq_dest_i     (enq_dest_i),
        .enq_rdy_o      (enq_rdy_o),
        .dc_req_o       (dc_req_o),
        .dc_addr_o      (dc_addr_o),
        .dc_id_o        (dc_id_o),
        .dc_ack_i       (dc_ack_i),
        .dc_cmp_i       (dc_cmp_i),
        .dc_cmp_id_i    (dc_cmp_id_i),
        .rp_vld_o       (rp_vld_o),
        .rp_rob_o       (rp_rob_o),
        .rp_op_o        (rp_op_o),
        .rp_addr_o      (rp_addr_o),
        .rp_dest_o      (rp_dest_o),
        .rp_rdy_i       (rp_rdy_i),
        .full_o         (full_o),
        .empty_o        (empty_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic rp_t mk_rp(input logic [5:0] rob, input logic [31:0] addr);
        rp_t e;
        e.rob  = rob;
        e.op   = rob[2:0];
        e.addr = addr;
        e.dest = ~rob;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_enq(input logic [5:0] rob, input logic [31:0] addr);
        enq_vld_i  = 1'b1;
        enq_rob_i  = rob;
        enq_op_i   = rob[2:0];
        enq_addr_i = addr;
        enq_dest_i = ~rob;
    endtask

    task automatic push_rf(input logic [31:0] addr, input logic [IDW-1:0] id);
        rf_t e;
        e.addr = addr;
        e.id   = id;
        rf_q.push_back(e);
    endtask

    task automatic enq(input logic [5:0] rob, input logic [31:0] addr, input bit exp_rp);
        int t;
        drive_enq(rob, addr);
        #1;
        t = 0;
        while (!enq_rdy_o && t < 100) begin
            tick();
            #1;
            t++;
        end
        check_eq("enq_ready", enq_rdy_o, 1'b1);
        if (exp_rp && enq_rdy_o) rp_q.push_back(mk_rp(rob, addr));
        tick();
        enq_vld_i = 1'b0;
    endtask

    task automatic ack();
        int t;
        t = 0;
        while (!dc_req_o && t < 100) begin
            tick();
            t++;
        end
        check_eq("ack_req_seen", dc_req_o, 1'b1);
        dc_ack_i = 1'b1;
        tick();
        dc_ack_i = 1'b0;
    endtask

    task automatic cmp(input logic [IDW-1:0] id);
        check_eq("cmp_proto", tb_iss[id], 1'b1);
        tb_iss[id]  = 1'b0;
        dc_cmp_i    = 1'b1;
        dc_cmp_id_i = id;
        tick();
        dc_cmp_i    = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (rp_q.size() > 0 && t < 200) begin
            tick();
            t++;
        end
        check_eq("drain", rp_q.size(), 0);
    endtask

    // Monitor: scoreboard pops on handshakes and stability under backpressure
    rp_t         mon_e, hold_rp_v;
    rf_t         mon_f;
    logic        hold_rp = 1'b0, hold_rf = 1'b0;
    logic [31:0] hold_rf_addr;
    logic        hold_rf_id;
    always @(negedge clk) begin
        if (core_reset_n_i) begin
            if (hold_rp && rp_vld_o)
                check_eq("rp_stable", {rp_rob_o, rp_op_o, rp_addr_o, rp_dest_o},
                         {hold_rp_v.rob, hold_rp_v.op, hold_rp_v.addr, hold_rp_v.dest});
            if (hold_rf && dc_req_o)
                check_eq("rf_stable", {dc_addr_o, dc_id_o}, {hold_rf_addr, hold_rf_id});
            if (rp_vld_o && rp_rdy_i) begin
                check_eq("rp_expected", rp_q.size() > 0, 1'b1);
                if (rp_q.size() > 0) begin
                    mon_e = rp_q.pop_front();
                    check_eq("rp_rob", rp_rob_o, mon_e.rob);
                    check_eq("rp_op", rp_op_o, mon_e.op);
                    check_eq("rp_addr", rp_addr_o, mon_e.addr);
                    check_eq("rp_dest", rp_dest_o, mon_e.dest);
                end
            end
            if (dc_req_o && dc_ack_i) begin
                check_eq("rf_expected", rf_q.size() > 0, 1'b1);
                if (rf_q.size() > 0) begin
                    mon_f = rf_q.pop_front();
                    check_eq("rf_addr", dc_addr_o, mon_f.addr);
                    check_eq("rf_id", dc_id_o, mon_f.id);
                    tb_iss[mon_f.id] = 1'b1;
                end
            end
            hold_rp        = rp_vld_o & ~rp_rdy_i;
            hold_rp_v.rob  = rp_rob_o;
            hold_rp_v.op   = rp_op_o;
            hold_rp_v.addr = rp_addr_o;
            hold_rp_v.dest = rp_dest_o;
            hold_rf        = dc_req_o & ~dc_ack_i & ~core_flush_i;
            hold_rf_addr   = dc_addr_o;
            hold_rf_id     = dc_id_o;
        end
    end

    initial begin
        core_reset_n_i = 1'b0;
        core_flush_i   = 1'b0;
        enq_vld_i      = 1'b0;
        enq_rob_i      = 6'd0;
        enq_op_i       = 3'd0;
        enq_addr_i     = 32'd0;
        enq_dest_i     = 6'd0;
        dc_ack_i       = 1'b0;
        dc_cmp_i       = 1'b0;
        dc_cmp_id_i    = 1'b0;
        rp_rdy_i       = 1'b1;
        repeat (3) tick();
        core_reset_n_i = 1'b1;
        #1;
        check_eq("rst_dc_req", dc_req_o, 1'b0);
        check_eq("rst_rp_vld", rp_vld_o, 1'b0);
        check_eq("rst_full", full_o, 1'b0);
        check_eq("rst_empty", empty_o, 1'b1);
        check_eq("rst_enq_rdy", enq_rdy_o, 1'b1);

        // Single miss
        push_rf(32'h0000_1200, 1'b0);
        enq(6'd5, 32'h0000_1234, 1'b1);
        check_eq("sm_req", dc_req_o, 1'b1);
        check_eq("sm_addr", dc_addr_o, 32'h0000_1200);
        check_eq("sm_id", dc_id_o, 1'b0);
        ack();
        check_eq("sm_req_drop", dc_req_o, 1'b0);
        cmp(1'b0);
        check_eq("sm_rp_lat1", rp_vld_o, 1'b0);
        tick();
        check_eq("sm_rp_lat2", rp_vld_o, 1'b1);
        check_eq("sm_rp_rob", rp_rob_o, 6'd5);
        check_eq("sm_rp_addr", rp_addr_o, 32'h0000_1234);
        drain();

        // Merge
        push_rf(32'h0000_1200, 1'b0);
        push_rf(32'h0000_2000, 1'b1);
        enq(6'd1, 32'h0000_1200, 1'b1);
        enq(6'd2, 32'h0000_1240, 1'b1);
        enq(6'd3, 32'h0000_2000, 1'b1);
        ack();
        ack();
        check_eq("mg_two_refills", dc_req_o, 1'b0);
        cmp(1'b0);
        check_eq("mg_lat1", rp_vld_o, 1'b0);
        tick();
        check_eq("mg_first", {rp_vld_o, rp_rob_o}, {1'b1, 6'd1});
        tick();
        check_eq("mg_second", {rp_vld_o, rp_rob_o}, {1'b1, 6'd2});
        tick();
        check_eq("mg_gap", rp_vld_o, 1'b0);
        cmp(1'b1);
        drain();

        // Resource full: both MSHRs busy
        push_rf(32'h0000_3000, 1'b0);
        push_rf(32'h0000_4000, 1'b1);
        enq(6'd10, 32'h0000_3000, 1'b1);
        enq(6'd11, 32'h0000_4000, 1'b1);
        ack();
        ack();
        drive_enq(6'd12, 32'h0000_5000);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("rf_hold", enq_rdy_o, 1'b0);
            tick();
            #1;
        end
        check_eq("cmp_proto", tb_iss[0], 1'b1);
        tb_iss[0]   = 1'b0;
        dc_cmp_i    = 1'b1;
        dc_cmp_id_i = 1'b0;
        #1;
        check_eq("rf_same_cycle_cmp", enq_rdy_o, 1'b0);
        tick();
        dc_cmp_i = 1'b0;
        #1;
        check_eq("rf_freed", enq_rdy_o, 1'b1);
        rp_q.push_back(mk_rp(6'd12, 32'h0000_5000));
        push_rf(32'h0000_5000, 1'b0);
        tick();
        enq_vld_i = 1'b0;
        ack();
        cmp(1'b1);
        cmp(1'b0);
        drain();

        // Slot full with 8 same-line loads
        push_rf(32'h0000_6000, 1'b0);
        for (int i = 0; i < 8; i++) enq(6'(20 + i), 32'h0000_6000 + 32'(i * 4), 1'b1);
        check_eq("full_set", full_o, 1'b1);
        ack();
        drive_enq(6'd28, 32'h0000_6020);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq("full_hold", enq_rdy_o, 1'b0);
            tick();
            #1;
        end
        enq_vld_i = 1'b0;
        cmp(1'b0);
        drain();
        tick();
        check_eq("full_clear", full_o, 1'b0);
        check_eq("empty_after", empty_o, 1'b1);
        push_rf(32'h0000_6000, 1'b0);
        enq(6'd28, 32'h0000_6020, 1'b1);
        ack();
        cmp(1'b0);
        drain();

        // Lost wakeup: merge in the completion cycle
        push_rf(32'h0000_7000, 1'b0);
        enq(6'd30, 32'h0000_7000, 1'b1);
        ack();
        drive_enq(6'd31, 32'h0000_7040);
        check_eq("cmp_proto", tb_iss[0], 1'b1);
        tb_iss[0]   = 1'b0;
        dc_cmp_i    = 1'b1;
        dc_cmp_id_i = 1'b0;
        #1;
        check_eq("lw_rdy", enq_rdy_o, 1'b1);
        rp_q.push_back(mk_rp(6'd31, 32'h0000_7040));
        tick();
        enq_vld_i = 1'b0;
        dc_cmp_i  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("lw_no_refill", dc_req_o, 1'b0);
        end
        drain();

        // Flush after ack, before completion
        push_rf(32'h0000_8000, 1'b0);
        enq(6'd40, 32'h0000_8000, 1'b0);
        ack();
        core_flush_i = 1'b1;
        #1;
        check_eq("fl_enq_block", enq_rdy_o, 1'b0);
        tick();
        core_flush_i = 1'b0;
        check_eq("fl_rp_vld", rp_vld_o, 1'b0);
        check_eq("fl_mshr_kept", empty_o, 1'b0);
        cmp(1'b0);
        check_eq("fl_empty_after_cmp", empty_o, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check_eq("fl_no_wake", rp_vld_o, 1'b0);
            tick();
        end

        // Post-flush load merges into the surviving issued MSHR
        push_rf(32'h0000_9000, 1'b0);
        enq(6'd42, 32'h0000_9000, 1'b0);
        ack();
        core_flush_i = 1'b1;
        tick();
        core_flush_i = 1'b0;
        enq(6'd43, 32'h0000_9004, 1'b1);
        check_eq("fl_merge_no_req", dc_req_o, 1'b0);
        cmp(1'b0);
        drain();

        // Flush drops an unacknowledged request
        enq(6'd44, 32'h0000_A000, 1'b0);
        check_eq("fl_req_up", dc_req_o, 1'b1);
        core_flush_i = 1'b1;
        tick();
        core_flush_i = 1'b0;
        check_eq("fl_req_drop", dc_req_o, 1'b0);
        check_eq("fl_all_free", empty_o, 1'b1);

        // Backpressure with three woken slots
        push_rf(32'h0000_B000, 1'b0);
        enq(6'd50, 32'h0000_B000, 1'b1);
        enq(6'd51, 32'h0000_B008, 1'b1);
        enq(6'd52, 32'h0000_B010, 1'b1);
        ack();
        rp_rdy_i = 1'b0;
        cmp(1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check_eq("bp_hold", {rp_vld_o, rp_rob_o}, {1'b1, 6'd50});
            tick();
        end
        rp_rdy_i = 1'b1;
        check_eq("bp_r0", {rp_vld_o, rp_rob_o}, {1'b1, 6'd50});
        tick();
        check_eq("bp_r1", {rp_vld_o, rp_rob_o}, {1'b1, 6'd51});
        tick();
        check_eq("bp_r2", {rp_vld_o, rp_rob_o}, {1'b1, 6'd52});
        tick();
        check_eq("bp_done", rp_vld_o, 1'b0);
        drain();

        check_eq("rf_all_seen", rf_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_miss_queue.md
Name: load_miss_queue

Overview:
- Non-blocking successor to the single-miss weakly-ordered load path.
- Parks cacheable loads that missed in the data cache, and tracks up to NMSHR distinct outstanding line refills.
- Merges loads that hit an already-pending line, issues one refill request at a time to the dcache refill port, and replays woken loads to the load pipeline once per cycle.
- Sits between the load skid buffer / miss detect stage and the dcache refill engine.

Parameters:
- NMSHR, 2, number of concurrently outstanding line refills (power of two, 1..8).
- DEPTH, 8, number of parked-load slots (2..16).
- OFFB, 7, line offset bits; line address = addr[31:OFFB].
- IDW, $clog2(NMSHR) (minimum 1), refill tag width.

Ports:
- core_clock_i  in  1  core clock.
- core_reset_n_i  in  1  synchronous active-low reset.
- core_flush_i  in  1  pipeline flush; drops all parked loads.
- enq_vld_i  in  1  missed load presented.
- enq_rob_i  in  6  ROB id.
- enq_op_i  in  3  load op (size/sign).
- enq_addr_i  in  32  load byte address.
- enq_dest_i  in  6  physical destination.
- enq_rdy_o  out  1  slot and MSHR available (combinational).
- dc_req_o  out  1  refill request valid.
- dc_addr_o  out  32  line-aligned refill address (low OFFB bits zero).
- dc_id_o  out  IDW  MSHR tag of the request.
- dc_ack_i  in  1  refill request accepted.
- dc_cmp_i  in  1  refill complete, line written to SRAM.
- dc_cmp_id_i  in  IDW  tag of the completed refill.
- rp_vld_o  out  1  replay load valid.
- rp_rob_o  out  6  replay ROB id.
- rp_op_o  out  3  replay op.
- rp_addr_o  out  32  replay address.
- rp_dest_o  out  6  replay destination.
- rp_rdy_i  in  1  load pipeline accepts replay.
- full_o  out  1  no free parked-load slot.
- empty_o  out  1  no valid slot and no valid MSHR.

Behaviour:
- Reset: all slot and MSHR valid bits cleared. dc_req_o=0, rp_vld_o=0, full_o=0, empty_o=1. Data outputs are don't-care.
- Slot state: {valid, woken, id, rob, op, addr, dest}. MSHR state: {valid, issued, line}.
- enq_rdy_o = !core_flush_i & free slot exists & (line matches a valid MSHR | free MSHR exists).
- Enqueue (enq_vld_i & enq_rdy_o):
  - Load goes to the lowest free slot.
  - If its line matches a valid MSHR, it merges: id = that MSHR, no new refill.
  - Otherwise the lowest free MSHR is allocated: valid=1, issued=0.
- Lost-wakeup guard: if dc_cmp_i completes the MSHR the load merges into in the same cycle, the slot is written with woken=1.
- Refill issue: dc_req_o is registered.
  - Selects the lowest-index MSHR with valid & !issued.
  - Raised the cycle after allocation at the earliest.
  - dc_addr_o and dc_id_o are held stable while dc_req_o=1 & !dc_ack_i.
  - On dc_ack_i: issued=1. dc_req_o may re-assert the next cycle for another pending MSHR.
- Completion (dc_cmp_i): every valid slot whose id equals dc_cmp_id_i sets woken=1 next edge, and that MSHR is freed.
  - The freed MSHR is reallocatable from the following cycle. The same-cycle enqueue does not see it free.
  - dc_cmp_i for a non-issued or invalid tag is a protocol error; the bench asserts against it.
- Replay: registered valid/ready output.
  - Selects the lowest-index slot with valid & woken.
  - rp_* are stable while rp_vld_o & !rp_rdy_i.
  - On the handshake the slot is freed, and a new woken slot may be presented the next cycle (1 replay/cycle sustained).
  - cmp -> rp_vld_o latency = 2 cycles (woken set, then output register).
- Flush:
  - Next edge all slots invalid, rp_vld_o=0, unissued MSHRs freed, and dc_req_o dropped unless dc_ack_i is high that same cycle.
  - Issued MSHRs stay valid until their dc_cmp_i, waking nothing. They stay matchable, so post-flush loads to that line merge.
  - Enqueue is blocked in the flush cycle.
- Reset takes priority over flush, completion and enqueue.
- full_o and empty_o are registered from next-state counts.

Test Plan:
- Single miss:
  - Stimulus: enqueue addr 0x0000_1234, rob 5.
  - Required: dc_req_o next cycle with dc_addr_o=0x0000_1200, dc_id_o=0. Ack, then cmp id 0. rp_vld_o two cycles later with rob 5 and addr 0x0000_1234.
- Merge:
  - Stimulus: enqueue 0x1200 and 0x1240 (same line), then 0x2000.
  - Required: exactly two refills, ids 0 then 1. Completing id 0 replays the first two loads in slot order on consecutive cycles.
- Resource full:
  - Stimulus: with NMSHR=2, enqueue loads to 3 distinct lines.
  - Required: the third sees enq_rdy_o=0 until a cmp frees an MSHR. With DEPTH=8 and 8 same-line loads, full_o=1 and the ninth is held off.
- Lost wakeup:
  - Stimulus: enqueue a load to line L in the same cycle as dc_cmp_i for L's MSHR.
  - Required: that load is replayed; no new refill is issued.
- Flush mid-refill:
  - Stimulus: flush after ack, before cmp.
  - Required: rp_vld_o=0 and slots empty. A later cmp wakes nothing; empty_o=1 after the cmp.
- Backpressure:
  - Stimulus: hold rp_rdy_i=0 for 4 cycles with 3 woken slots.
  - Required: rp_* stable throughout, then 3 replays on 3 consecutive cycles.
